// File: rtl/vga_frame_reader.sv
// vga_frame_reader
//   Read side of the camera frame buffer. It generates 640x480@60 VGA timing,
//   strobes both SDRAM read FIFOs once per active pixel and rebuilds 10-bit RGB
//   from the two packed 16-bit words. A built-in colour-bar generator can
//   replace the FIFO data, and the mode is switched only on frame boundaries.
//
// Ports
//   clk, rst_n            pixel clock, synchronous active-low reset
//   iRD1_DATA             FIFO 1 word {x, G[9:5], B[9:0]}
//   iRD2_DATA             FIFO 2 word {x, G[4:0], R[9:0]}
//   iTest_Mode            0 = frame buffer, 1 = colour bars (sampled at (0,0))
//   oRequest              read strobe to both FIFOs (data valid one cycle later)
//   oVGA_R/G/B            10-bit colour, zero outside the active area
//   oH_SYNC, oV_SYNC      active-low syncs
//   oBLANK_N              high during active video
//   oFrame_Start          one-cycle pulse with output pixel (0,0)
//   oFrame_Cont           completed-frame counter
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] iRD1_DATA,
    input  logic [15:0] iRD2_DATA,
    input  logic        iTest_Mode,
    output logic        oRequest,
    output logic [9:0]  oVGA_R,
    output logic [9:0]  oVGA_G,
    output logic [9:0]  oVGA_B,
    output logic        oH_SYNC,
    output logic        oV_SYNC,
    output logic        oBLANK_N,
    output logic        oFrame_Start,
    output logic [15:0] oFrame_Cont
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = 80;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    // counters and frame-level state
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          mode_q, mode_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    // stage 1: flags for the pixel whose FIFO data is arriving this cycle
    logic          s1_act_q, s1_act_d;
    logic          s1_hs_n_q, s1_hs_n_d;
    logic          s1_vs_n_q, s1_vs_n_d;
    logic          s1_fs_q, s1_fs_d;
    logic [HW-1:0] s1_x_q, s1_x_d;

    // stage 2: output registers
    logic [9:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          hs_n_q, hs_n_d, vs_n_q, vs_n_d;
    logic          blank_n_q, blank_n_d, fs_q, fs_d;

    logic          active_now, at_origin, at_wrap;
    logic [2:0]    bar;

    // FIFO bit 15 carries nothing
    logic          unused_bits;
    assign unused_bits = iRD1_DATA[15] ^ iRD2_DATA[15];

    assign active_now = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign at_wrap    = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    // Gated with rst_n so no read is issued while the block is held in reset;
    // the counters sit at (0,0), so the first request follows release at once.
    assign oRequest = rst_n & active_now;

    always_comb begin
        h_cnt_d     = h_cnt_q + 1'b1;
        v_cnt_d     = v_cnt_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
        // mode is only taken at the frame origin so a frame never mixes sources
        if (at_origin) mode_d = iTest_Mode;
        if (at_wrap)   frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_comb begin
        s1_act_d  = active_now;
        s1_hs_n_d = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        s1_vs_n_d = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        s1_fs_d   = at_origin;
        s1_x_d    = h_cnt_q;
    end

    // colour for the stage-1 pixel, using FIFO data valid this cycle
    always_comb begin
        r_d       = '0;
        g_d       = '0;
        b_d       = '0;
        bar       = '0;
        hs_n_d    = s1_hs_n_q;
        vs_n_d    = s1_vs_n_q;
        blank_n_d = s1_act_q;
        fs_d      = s1_fs_q;
        if (s1_act_q) begin
            if (mode_q) begin
                // bar index bits: [2]=no green, [1]=no red, [0]=no blue
                bar = 3'(s1_x_q / HW'(BAR_W));
                r_d = {10{~bar[1]}};
                g_d = {10{~bar[2]}};
                b_d = {10{~bar[0]}};
            end else begin
                r_d = iRD2_DATA[9:0];
                g_d = {iRD1_DATA[14:10], iRD2_DATA[14:10]};
                b_d = iRD1_DATA[9:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            mode_q      <= 1'b0;
            frame_cnt_q <= '0;
            s1_act_q    <= 1'b0;
            s1_hs_n_q   <= 1'b1;
            s1_vs_n_q   <= 1'b1;
            s1_fs_q     <= 1'b0;
            s1_x_q      <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            hs_n_q      <= 1'b1;
            vs_n_q      <= 1'b1;
            blank_n_q   <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            s1_act_q    <= s1_act_d;
            s1_hs_n_q   <= s1_hs_n_d;
            s1_vs_n_q   <= s1_vs_n_d;
            s1_fs_q     <= s1_fs_d;
            s1_x_q      <= s1_x_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            hs_n_q      <= hs_n_d;
            vs_n_q      <= vs_n_d;
            blank_n_q   <= blank_n_d;
            fs_q        <= fs_d;
        end
    end

    assign oVGA_R       = r_q;
    assign oVGA_G       = g_q;
    assign oVGA_B       = b_q;
    assign oH_SYNC      = hs_n_q;
    assign oV_SYNC      = vs_n_q;
    assign oBLANK_N     = blank_n_q;
    assign oFrame_Start = fs_q;
    assign oFrame_Cont  = frame_cnt_q;

endmodule
